// File: rtl/ctrl_opcode_encoder_if.sv
// Handshake bundle for ctrl_opcode_encoder: control-bundle input side, opcode FIFO output side, flush.
// The slave modport is the encoder; the master modport is the producer/consumer driving it.
interface ctrl_opcode_encoder_if;
    logic       InValid;
    logic       InReady;
    logic       RegDst;
    logic       Jump;
    logic       Branch;
    logic       MemRead;
    logic       MemToReg;
    logic       MemWrite;
    logic       ALUSrc;
    logic       RegWrite;
    logic [1:0] ALUOp;
    logic       Flush;
    logic       OutValid;
    logic       OutReady;
    logic [5:0] OutOpCode;
    logic       OutIllegal;

    modport master (
        output InValid, RegDst, Jump, Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite,
        output ALUOp, Flush, OutReady,
        input  InReady, OutValid, OutOpCode, OutIllegal
    );

    modport slave (
        input  InValid, RegDst, Jump, Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite,
        input  ALUOp, Flush, OutReady,
        output InReady, OutValid, OutOpCode, OutIllegal
    );
endinterface

// File: rtl/ctrl_opcode_encoder.sv
// Recovers the MIPS opcode from a control-signal bundle and queues it in a small FIFO.
// Optional saturating statistics counters are built when CTRL_ENC_STATS_EN is defined.
module ctrl_opcode_encoder #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    ctrl_opcode_encoder_if.slave      bus,
    output logic [15:0]               EncCount,
    output logic [15:0]               IllegalCount
);

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [6:0]       mem_q [DEPTH];
    logic [6:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic       is_bubble;
    logic [5:0] dec_opcode;
    logic       dec_illegal;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;

    // Each pattern lists every bit it cares about; bits marked ignored are simply absent.
    always_comb begin
        dec_opcode  = 6'b111111;
        dec_illegal = 1'b1;
        is_bubble   = 1'b0;
        if (bus.RegDst && !bus.ALUSrc && !bus.MemToReg && bus.RegWrite && !bus.MemRead &&
            !bus.MemWrite && !bus.Branch && !bus.Jump && bus.ALUOp == 2'b10) begin
            dec_opcode  = 6'b000000;
            dec_illegal = 1'b0;
        end else if (!bus.RegDst && bus.ALUSrc && bus.MemToReg && bus.RegWrite && bus.MemRead &&
                     !bus.MemWrite && !bus.Branch && !bus.Jump && bus.ALUOp == 2'b00) begin
            dec_opcode  = 6'b100011;
            dec_illegal = 1'b0;
        end else if (bus.ALUSrc && !bus.RegWrite && !bus.MemRead && bus.MemWrite &&
                     !bus.Branch && !bus.Jump && bus.ALUOp == 2'b00) begin
            dec_opcode  = 6'b101011;
            dec_illegal = 1'b0;
        end else if (!bus.RegDst && !bus.MemToReg && !bus.ALUSrc && !bus.RegWrite && !bus.MemRead &&
                     !bus.MemWrite && bus.Branch && !bus.Jump && bus.ALUOp == 2'b01) begin
            dec_opcode  = 6'b000101;
            dec_illegal = 1'b0;
        end else if (!bus.RegDst && bus.ALUSrc && !bus.MemToReg && bus.RegWrite && !bus.MemRead &&
                     !bus.MemWrite && !bus.Branch && !bus.Jump && bus.ALUOp == 2'b11) begin
            dec_opcode  = 6'b001110;
            dec_illegal = 1'b0;
        end else if (!bus.RegDst && !bus.ALUSrc && !bus.MemToReg && !bus.RegWrite && !bus.MemRead &&
                     !bus.MemWrite && !bus.Branch && bus.Jump && bus.ALUOp == 2'b00) begin
            dec_opcode  = 6'b000010;
            dec_illegal = 1'b0;
        end else if (!bus.RegDst && !bus.ALUSrc && !bus.MemToReg && !bus.RegWrite && !bus.MemRead &&
                     !bus.MemWrite && !bus.Branch && !bus.Jump && bus.ALUOp == 2'b10) begin
            is_bubble = 1'b1;
        end
    end

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    // Bubbles are acknowledged through InReady but never occupy a slot.
    assign push  = bus.InValid && !full && !is_bubble && !bus.Flush;
    assign pop   = !empty && bus.OutReady && !bus.Flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {dec_illegal, dec_opcode};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign bus.InReady    = !full;
    assign bus.OutValid   = !empty;
    assign bus.OutOpCode  = mem_q[rd_ptr_q][5:0];
    assign bus.OutIllegal = mem_q[rd_ptr_q][6];

`ifdef CTRL_ENC_STATS_EN
    logic [15:0] enc_cnt_q, enc_cnt_d;
    logic [15:0] ill_cnt_q, ill_cnt_d;

    // Counters survive Flush and stick at all-ones.
    always_comb begin
        enc_cnt_d = enc_cnt_q;
        ill_cnt_d = ill_cnt_q;
        if (push && enc_cnt_q != 16'hFFFF) begin
            enc_cnt_d = enc_cnt_q + 16'd1;
        end
        if (push && dec_illegal && ill_cnt_q != 16'hFFFF) begin
            ill_cnt_d = ill_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            enc_cnt_q <= '0;
            ill_cnt_q <= '0;
        end else begin
            enc_cnt_q <= enc_cnt_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign EncCount     = enc_cnt_q;
    assign IllegalCount = ill_cnt_q;
`else
    assign EncCount     = '0;
    assign IllegalCount = '0;
`endif

endmodule

// File: tb/tb_ctrl_opcode_encoder.sv
// Directed-vector bench for ctrl_opcode_encoder; stats expectations follow CTRL_ENC_STATS_EN.
module tb_ctrl_opcode_encoder;

    logic        Clk;
    logic        Rst_n;
    logic [15:0] EncCount;
    logic [15:0] IllegalCount;
    int          n_cmp;
    int          n_fail;
    int          exp_enc;
    int          exp_ill;

    ctrl_opcode_encoder_if bus ();

    ctrl_opcode_encoder #(.DEPTH(4), .PTR_W(2)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .bus          (bus.slave),
        .EncCount     (EncCount),
        .IllegalCount (IllegalCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Order: RegDst Jump Branch MemRead MemToReg MemWrite ALUSrc RegWrite, ALUOp
    task automatic set_bundle(input logic [7:0] bits, input logic [1:0] aluop);
        {bus.RegDst, bus.Jump, bus.Branch, bus.MemRead, bus.MemToReg,
         bus.MemWrite, bus.ALUSrc, bus.RegWrite} = bits;
        bus.ALUOp = aluop;
    endtask

    task automatic bundle_lw();   set_bundle(8'b0001_1011, 2'b00); endtask
    task automatic bundle_r();    set_bundle(8'b1000_0001, 2'b10); endtask
    task automatic bundle_sw();   set_bundle(8'b1000_1110, 2'b00); endtask
    task automatic bundle_bne();  set_bundle(8'b0010_0000, 2'b01); endtask
    task automatic bundle_xori(); set_bundle(8'b0000_0011, 2'b11); endtask
    task automatic bundle_j();    set_bundle(8'b0100_0000, 2'b00); endtask

    function automatic int stat(input int v);
`ifdef CTRL_ENC_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic test_reset();
        Rst_n = 1'b0;
        bus.InValid = 1'b0; bus.Flush = 1'b0; bus.OutReady = 1'b0;
        set_bundle(8'h00, 2'b00);
        #12;
        n_cmp++;
        if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_hs: OutValid=%b InReady=%b want 0/1", bus.OutValid, bus.InReady);
        end
        n_cmp++;
        if (bus.OutOpCode !== 6'b0 || bus.OutIllegal !== 1'b0 || EncCount !== 16'd0 || IllegalCount !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: op=%b ill=%b enc=%0d illc=%0d want 0", bus.OutOpCode, bus.OutIllegal, EncCount, IllegalCount);
        end
        Rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_lw();
        bundle_lw(); bus.InValid = 1'b1;
        step();
        bus.InValid = 1'b0;
        n_cmp++;
        if (bus.OutValid !== 1'b1 || bus.OutOpCode !== 6'b100011 || bus.OutIllegal !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL lw_head: v=%b op=%b ill=%b want 1/100011/0", bus.OutValid, bus.OutOpCode, bus.OutIllegal);
        end
        exp_enc = 1;
        bus.OutReady = 1'b1;
        step();
        bus.OutReady = 1'b0;
        n_cmp++;
        if (bus.OutValid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL lw_drain: OutValid=%b want 0", bus.OutValid);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_ops [4];
        exp_ops[0] = 6'b101011; exp_ops[1] = 6'b000101; exp_ops[2] = 6'b001110; exp_ops[3] = 6'b000010;
        bus.InValid = 1'b1;
        bundle_r();    step();
        bundle_sw();   step();
        bundle_bne();  step();
        bundle_xori(); step();
        n_cmp++;
        if (bus.InReady !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL full_ready: InReady=%b want 0", bus.InReady);
        end
        bundle_j(); step();
        n_cmp++;
        if (bus.InReady !== 1'b0 || bus.OutOpCode !== 6'b000000) begin
            n_fail++;
            $display("[TB] FAIL held_j: InReady=%b head=%b want 0/000000", bus.InReady, bus.OutOpCode);
        end
        bus.OutReady = 1'b1;
        step();
        bus.OutReady = 1'b0;
        n_cmp++;
        if (bus.InReady !== 1'b1 || bus.OutOpCode !== 6'b101011) begin
            n_fail++;
            $display("[TB] FAIL pop_full: InReady=%b head=%b want 1/101011", bus.InReady, bus.OutOpCode);
        end
        step();
        bus.InValid = 1'b0;
        exp_enc += 5;
        bus.OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.OutValid !== 1'b1 || bus.OutOpCode !== exp_ops[i]) begin
                n_fail++;
                $display("[TB] FAIL drain_%0d: v=%b op=%b want 1/%b", i, bus.OutValid, bus.OutOpCode, exp_ops[i]);
            end
            step();
        end
        bus.OutReady = 1'b0;
        n_cmp++;
        if (bus.OutValid !== 1'b0 || EncCount !== 16'(stat(exp_enc))) begin
            n_fail++;
            $display("[TB] FAIL drain_end: v=%b enc=%0d want 0/%0d", bus.OutValid, EncCount, stat(exp_enc));
        end
    endtask

    task automatic test_bubble();
        set_bundle(8'h00, 2'b10);
        bus.InValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b1 || EncCount !== 16'(stat(exp_enc))) begin
                n_fail++;
                $display("[TB] FAIL bubble_%0d: v=%b rdy=%b enc=%0d want 0/1/%0d", i, bus.OutValid, bus.InReady, EncCount, stat(exp_enc));
            end
        end
        bus.InValid = 1'b0;
    endtask

    task automatic test_illegal();
        set_bundle(8'b0100_0001, 2'b00);
        bus.InValid = 1'b1;
        step();
        bus.InValid = 1'b0;
        exp_enc += 1;
        exp_ill = 1;
        n_cmp++;
        if (bus.OutValid !== 1'b1 || bus.OutOpCode !== 6'b111111 || bus.OutIllegal !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL illegal_head: v=%b op=%b ill=%b want 1/111111/1", bus.OutValid, bus.OutOpCode, bus.OutIllegal);
        end
        n_cmp++;
        if (IllegalCount !== 16'(stat(exp_ill)) || EncCount !== 16'(stat(exp_enc))) begin
            n_fail++;
            $display("[TB] FAIL illegal_stats: illc=%0d enc=%0d want %0d/%0d", IllegalCount, EncCount, stat(exp_ill), stat(exp_enc));
        end
        bus.OutReady = 1'b1;
        step();
        bus.OutReady = 1'b0;
    endtask

    task automatic test_flush();
        bus.InValid = 1'b1;
        bundle_lw(); step();
        bundle_sw(); step();
        exp_enc += 2;
        bundle_r();
        bus.Flush = 1'b1; bus.OutReady = 1'b1;
        step();
        bus.Flush = 1'b0; bus.OutReady = 1'b0; bus.InValid = 1'b0;
        n_cmp++;
        if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL flush_state: v=%b rdy=%b want 0/1", bus.OutValid, bus.InReady);
        end
        step();
        n_cmp++;
        if (bus.OutValid !== 1'b0 || EncCount !== 16'(stat(exp_enc))) begin
            n_fail++;
            $display("[TB] FAIL flush_noenq: v=%b enc=%0d want 0/%0d", bus.OutValid, EncCount, stat(exp_enc));
        end
    endtask

    task automatic test_async_reset();
        bus.InValid = 1'b1;
        bundle_xori(); step();
        bundle_bne();  step();
        #2;
        Rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b1 || bus.OutOpCode !== 6'b0 || EncCount !== 16'd0 || IllegalCount !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL async_rst: v=%b rdy=%b op=%b enc=%0d illc=%0d want 0/1/0/0/0",
                     bus.OutValid, bus.InReady, bus.OutOpCode, EncCount, IllegalCount);
        end
        step();
        step();
        #2;
        Rst_n = 1'b1;
        bundle_sw();
        step();
        bus.InValid = 1'b0;
        n_cmp++;
        if (bus.OutValid !== 1'b1 || bus.OutOpCode !== 6'b101011 || bus.OutIllegal !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL post_rst_push: v=%b op=%b ill=%b want 1/101011/0", bus.OutValid, bus.OutOpCode, bus.OutIllegal);
        end
        n_cmp++;
        if (EncCount !== 16'(stat(1))) begin
            n_fail++;
            $display("[TB] FAIL post_rst_enc: enc=%0d want %0d", EncCount, stat(1));
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; exp_enc = 0; exp_ill = 0;
        test_reset();
        test_single_lw();
        test_back_to_back();
        test_bubble();
        test_illegal();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
